// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage in front of the 32-bit combinational (gate-level) ALU.
// Requests are buffered in a small FIFO. One request at a time is loaded into
// the operand register that drives the ALU. The operands are held for SETTLE
// cycles so the ALU output can settle. Result, flags and tag are then captured
// into an output register and offered downstream. A saturating counter keeps
// track of how many captured operations reported overflow.
//
// Ports:
//   clk, reset       single rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready, in_a, in_b, in_cmd, in_tag
//                    request input (FIFO push side)
//   alu_a, alu_b, alu_cmd
//                    registered operands/command driven into the ALU
//   alu_result, alu_carryout, alu_zero, alu_overflow
//                    combinational ALU response
//   out_valid/out_ready, out_result, out_carryout, out_zero, out_overflow,
//   out_tag          captured result (output register side)
//   ovf_count        saturating count of captured ops with overflow set
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holds valid and its payload stable until the
// transfer. ready may depend only on registered state. ready while valid is 0
// has no effect.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DEPTH  = 4,   // FIFO entries, power of two, >= 2
    parameter int SETTLE = 2,   // operand hold cycles before sampling, >= 1
    parameter int TAG_W  = 4    // opaque tag width
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_cmd,
    input  logic [TAG_W-1:0] in_tag,

    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carryout,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [TAG_W-1:0] out_tag,

    output logic [7:0]       ovf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int ENT_W = 32 + 32 + 3 + TAG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Request FIFO
    // -----------------------------------------------------------------------
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    state_t           state;
    logic [SET_W-1:0] cnt;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [ENT_W-1:0] head;

    // in_ready is derived from the registered count only, so a pop in the
    // same cycle never lets a push into a full FIFO.
    assign in_ready   = (count != CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = in_valid && in_ready;
    // The FSM takes the head exactly when it leaves IDLE.
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr];

    // Storage carries no reset: contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_cmd, in_tag};
        end
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // natural rollover of the increment is the modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM, operand register, output register, overflow counter
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0] op_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cmd      <= '0;
            op_tag       <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_tag      <= '0;
            ovf_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_a   <= head[ENT_W-1 -: 32];
                        alu_b   <= head[ENT_W-33 -: 32];
                        alu_cmd <= head[TAG_W+2 -: 3];
                        op_tag  <= head[TAG_W-1:0];
                        cnt     <= SET_W'(SETTLE);
                        state   <= EXEC;
                    end
                end

                // Operands are untouched here, giving the ALU SETTLE full
                // cycles of stable inputs before the capture edge.
                EXEC: begin
                    if (cnt == SET_W'(1)) begin
                        out_result   <= alu_result;
                        out_carryout <= alu_carryout;
                        out_zero     <= alu_zero;
                        out_overflow <= alu_overflow;
                        out_tag      <= op_tag;
                        out_valid    <= 1'b1;
                        if (alu_overflow && (ovf_count != 8'hFF)) begin
                            ovf_count <= ovf_count + 8'd1;
                        end
                        state <= OUT;
                    end else begin
                        cnt <= cnt - SET_W'(1);
                    end
                end

                // Output register stays frozen until the consumer takes it.
                // alu_a/alu_b/alu_cmd keep their last values on purpose.
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
